// File: rtl/key_sel_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// key_sel_ctrl_pkg
// Shared constants and types for the push-button select controller that
// drives the 4:1 mux tree (two levels of mux21).
//   SEL_W      : width of the mux-tree select
//   NUM_MUX_IN : number of data inputs of the mux tree
//   mode_e     : select-generation mode (MANUAL / AUTO)
//   sel_next   : modulo increment of the select (3 -> 0 wrap)
// ----------------------------------------------------------------------------
package key_sel_ctrl_pkg;

   localparam int SEL_W      = 2;
   localparam int NUM_MUX_IN = 4;

   typedef enum logic [0:0] {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_e;

   // Wraps naturally through truncation to SEL_W bits
   function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s);
      return s + {{(SEL_W-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/key_sel_ctrl_key_debounce.sv
// ----------------------------------------------------------------------------
// key_debounce
// Synchronises one raw active-low push-button, debounces it and emits a
// one-cycle pulse on each accepted press (released -> pressed transition).
// Parameters:
//   DEBOUNCE_CYCLES : consecutive stable synchronised cycles before a new
//                     level is accepted (>= 2)
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   key_n  in  raw button, low = pressed, asynchronous to clk
//   press  out registered one-cycle pulse per accepted press
// ----------------------------------------------------------------------------
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta_q, meta_d;
   logic             sync_q, sync_d;
   logic             deb_q, deb_d;
   logic             deb_prev_q, deb_prev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;

   // Next-state logic: synchroniser shift, debounce counter, press edge
   always_comb begin
      meta_d     = key_n;
      sync_d     = meta_q;
      deb_d      = deb_q;
      cnt_d      = cnt_q;
      deb_prev_d = deb_q;
      // Any return to the accepted level restarts the stability window
      if (sync_q == deb_q) begin
         cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
         deb_d = sync_q;
         cnt_d = {CNT_W{1'b0}};
      end else begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // Only the 1 -> 0 (press) transition of the debounced level is reported
      press_d = deb_prev_q & ~deb_q;
   end

   // State registers; released (1) is the idle level for all key flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q     <= 1'b1;
         sync_q     <= 1'b1;
         deb_q      <= 1'b1;
         deb_prev_q <= 1'b1;
         cnt_q      <= {CNT_W{1'b0}};
         press_q    <= 1'b0;
      end else begin
         meta_q     <= meta_d;
         sync_q     <= sync_d;
         deb_q      <= deb_d;
         deb_prev_q <= deb_prev_d;
         cnt_q      <= cnt_d;
         press_q    <= press_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/key_sel_ctrl.sv
// ----------------------------------------------------------------------------
// key_sel_ctrl
// Generates the 2-bit select of the mux41 tree from two push-buttons.
// "next" advances the select in manual mode; "mode" toggles between manual
// stepping and automatic advance every AUTO_PERIOD cycles.
// Parameters:
//   DEBOUNCE_CYCLES : key stability window in cycles (>= 2)
//   AUTO_PERIOD     : cycles between automatic advances (>= 2)
// Ports:
//   clk         in  system clock (12 MHz)
//   rst_n       in  asynchronous active-low reset
//   key_next_n  in  raw "next" button, low = pressed
//   key_mode_n  in  raw "mode" button, low = pressed
//   sel         out registered select; sel[0] first-level, sel[1] second-level
//   auto_mode   out registered, 1 = automatic scan
//   sel_chg     out registered pulse in the first cycle sel shows a new value
// ----------------------------------------------------------------------------
module key_sel_ctrl
   import key_sel_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int AUTO_PERIOD     = 12000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_next_n,
   input  logic             key_mode_n,
   output logic [SEL_W-1:0] sel,
   output logic             auto_mode,
   output logic             sel_chg
);

   localparam int TICK_W = $clog2(AUTO_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);

   logic              next_press;
   logic              mode_press;
   mode_e             state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic              sel_chg_q, sel_chg_d;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_next (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_next_n),
      .press (next_press)
   );

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_deb_mode (
      .clk   (clk),
      .rst_n (rst_n),
      .key_n (key_mode_n),
      .press (mode_press)
   );

   // Mode FSM, tick counter and select update; a mode press always wins
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      sel_d     = sel_q;
      sel_chg_d = 1'b0;
      case (state_q)
         MANUAL: begin
            if (mode_press) begin
               // Tick restarts so the first advance is a full period away
               state_d = AUTO;
               tick_d  = {TICK_W{1'b0}};
            end else if (next_press) begin
               sel_d     = sel_next(sel_q);
               sel_chg_d = 1'b1;
            end else begin
               tick_d = {TICK_W{1'b0}};
            end
         end
         AUTO: begin
            if (mode_press) begin
               state_d = MANUAL;
               tick_d  = {TICK_W{1'b0}};
            end else if (tick_q == TICK_LAST) begin
               tick_d    = {TICK_W{1'b0}};
               sel_d     = sel_next(sel_q);
               sel_chg_d = 1'b1;
            end else begin
               tick_d = tick_q + {{(TICK_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = MANUAL;
            tick_d  = {TICK_W{1'b0}};
         end
      endcase
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= MANUAL;
         tick_q    <= {TICK_W{1'b0}};
         sel_q     <= {SEL_W{1'b0}};
         sel_chg_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         sel_q     <= sel_d;
         sel_chg_q <= sel_chg_d;
      end
   end

   assign sel       = sel_q;
   assign sel_chg   = sel_chg_q;
   assign auto_mode = (state_q == AUTO);

endmodule

// File: tb/tb_key_sel_ctrl.sv
// ----------------------------------------------------------------------------
// tb_key_sel_ctrl
// Scoreboard bench: every expected select update (cycle number and value) is
// queued when the key stimulus is applied; a monitor pops and compares on
// each sel_chg pulse and flags any sel change that is not paired with one.
// ----------------------------------------------------------------------------
module tb_key_sel_ctrl;

   localparam int DC  = 8;
   localparam int AP  = 16;
   localparam int LAT = DC + 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       key_next_n;
   logic       key_mode_n;
   logic [1:0] sel;
   logic       auto_mode;
   logic       sel_chg;

   key_sel_ctrl #(
      .DEBOUNCE_CYCLES(DC),
      .AUTO_PERIOD    (AP)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_next_n (key_next_n),
      .key_mode_n (key_mode_n),
      .sel        (sel),
      .auto_mode  (auto_mode),
      .sel_chg    (sel_chg)
   );

   always #5 clk = ~clk;

   // Number of rising edges seen so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         edge_n;
      logic [1:0] sel;
   } exp_t;

   exp_t       sb_q[$];
   exp_t       mon_e;
   int         errors = 0;
   int         checks = 0;
   logic [1:0] prev_sel = 2'd0;
   logic [1:0] model_sel = 2'd0;
   int         auto_e = 0;

   task automatic push_exp(input int edge_n, input logic [1:0] s);
      exp_t e;
      e.edge_n = edge_n;
      e.sel    = s;
      sb_q.push_back(e);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // Monitor: pairs sel changes with sel_chg and pops the scoreboard
   always @(posedge clk) begin
      #1;
      if (rst_n !== 1'b1) begin
         prev_sel = sel;
      end else begin
         checks++;
         if ((sel != prev_sel) !== sel_chg) begin
            errors++;
            $display("FAIL chg_pairing: cyc=%0d sel_chg=%b required %b (sel=%0d prev=%0d)",
                     cyc, sel_chg, (sel != prev_sel), sel, prev_sel);
         end
         if (sel_chg === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_sel_chg: cyc=%0d sel=%0d, no update was expected", cyc, sel);
            end else begin
               mon_e = sb_q.pop_front();
               checks++;
               if (cyc !== mon_e.edge_n) begin
                  errors++;
                  $display("FAIL sel_edge: update at cyc=%0d required cyc=%0d", cyc, mon_e.edge_n);
               end
               if (sel !== mon_e.sel) begin
                  errors++;
                  $display("FAIL sel_value: cyc=%0d sel=%0d required %0d", cyc, sel, mon_e.sel);
               end
            end
         end
         prev_sel = sel;
      end
   end

   task automatic test_reset;
      rst_n      = 1'b0;
      key_next_n = 1'b1;
      key_mode_n = 1'b1;
      #1;
      checks += 3;
      if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: sel=%0d required 0", sel); end
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL reset_auto: auto_mode=%b required 0", auto_mode); end
      if (sel_chg !== 1'b0) begin errors++; $display("FAIL reset_chg: sel_chg=%b required 0", sel_chg); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean_press;
      int n;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n = cyc;
         key_next_n = 1'b0;
         model_sel  = model_sel + 2'd1;
         push_exp(n + LAT, model_sel);
         wait_cyc(n + LAT - 1);
         checks++;
         if (sel === model_sel) begin
            errors++;
            $display("FAIL press_early: press %0d sel=%0d one edge before the update", i, sel);
         end
         wait_cyc(n + 20);
         key_next_n = 1'b1;
         wait_cyc(n + 40);
         checks++;
         if (sel !== model_sel) begin
            errors++;
            $display("FAIL press_sel: press %0d sel=%0d required %0d", i, sel, model_sel);
         end
      end
   endtask

   task automatic test_bounce;
      int n;
      @(negedge clk);
      n = cyc;
      key_next_n = 1'b0;
      wait_cyc(n + 5);
      key_next_n = 1'b1;
      wait_cyc(n + 7);
      key_next_n = 1'b0;
      wait_cyc(n + 12);
      key_next_n = 1'b1;
      wait_cyc(n + 40);
      checks += 2;
      if (sel !== model_sel) begin
         errors++;
         $display("FAIL bounce_sel: sel=%0d required %0d", sel, model_sel);
      end
      if (sb_q.size() !== 0) begin
         errors++;
         $display("FAIL bounce_pending: %0d pending updates required 0", sb_q.size());
      end
   endtask

   task automatic test_auto;
      int         n;
      int         e;
      logic [1:0] s;
      @(negedge clk);
      n = cyc;
      e = n + LAT;
      auto_e = e;
      key_mode_n = 1'b0;
      s = model_sel;
      for (int k = 1; k <= 4; k++) begin
         s = s + 2'd1;
         push_exp(e + AP * k, s);
      end
      wait_cyc(e - 1);
      checks++;
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL auto_early: auto_mode=%b required 0", auto_mode); end
      wait_cyc(e);
      checks++;
      if (auto_mode !== 1'b1) begin errors++; $display("FAIL auto_enter: auto_mode=%b required 1", auto_mode); end
      wait_cyc(n + 20);
      key_mode_n = 1'b1;
      // Next press landing between ticks must be ignored in auto mode
      wait_cyc(e + 28);
      key_next_n = 1'b0;
      wait_cyc(e + 43);
      key_next_n = 1'b1;
      wait_cyc(e + 66);
      checks += 2;
      if (sel !== model_sel) begin errors++; $display("FAIL auto_wrap: sel=%0d required %0d", sel, model_sel); end
      if (sb_q.size() !== 0) begin errors++; $display("FAIL auto_pending: %0d pending updates required 0", sb_q.size()); end
   endtask

   task automatic test_priority_auto;
      // Mode press lands on the fifth tick edge
      wait_cyc(auto_e + 5 * AP - LAT);
      key_mode_n = 1'b0;
      wait_cyc(auto_e + 5 * AP - 1);
      checks++;
      if (auto_mode !== 1'b1) begin errors++; $display("FAIL prio_auto_pre: auto_mode=%b required 1", auto_mode); end
      wait_cyc(auto_e + 5 * AP);
      checks += 2;
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL prio_auto_mode: auto_mode=%b required 0", auto_mode); end
      if (sel !== model_sel) begin errors++; $display("FAIL prio_auto_sel: sel=%0d required %0d", sel, model_sel); end
      wait_cyc(auto_e + 5 * AP + 8);
      key_mode_n = 1'b1;
      wait_cyc(auto_e + 7 * AP + 4);
      checks += 2;
      if (sel !== model_sel) begin errors++; $display("FAIL prio_auto_hold: sel=%0d required %0d", sel, model_sel); end
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL prio_auto_stay: auto_mode=%b required 0", auto_mode); end
   endtask

   task automatic test_priority_manual;
      int n;
      int e;
      @(negedge clk);
      n = cyc;
      e = n + LAT;
      key_mode_n = 1'b0;
      key_next_n = 1'b0;
      wait_cyc(e - 1);
      checks++;
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL prio_man_pre: auto_mode=%b required 0", auto_mode); end
      wait_cyc(e);
      checks += 2;
      if (auto_mode !== 1'b1) begin errors++; $display("FAIL prio_man_mode: auto_mode=%b required 1", auto_mode); end
      if (sel !== model_sel) begin errors++; $display("FAIL prio_man_sel: sel=%0d required %0d", sel, model_sel); end
      auto_e = e;
      wait_cyc(n + 20);
      key_mode_n = 1'b1;
      key_next_n = 1'b1;
   endtask

   task automatic test_reset_mid;
      push_exp(auto_e + AP, model_sel + 2'd1);
      push_exp(auto_e + 2 * AP, model_sel + 2'd2);
      wait_cyc(auto_e + 2 * AP - 1);
      @(posedge clk);
      #2;
      checks += 3;
      if (sel !== model_sel + 2'd2) begin errors++; $display("FAIL mid_sel: sel=%0d required %0d", sel, model_sel + 2'd2); end
      if (auto_mode !== 1'b1) begin errors++; $display("FAIL mid_auto: auto_mode=%b required 1", auto_mode); end
      if (sel_chg !== 1'b1) begin errors++; $display("FAIL mid_chg: sel_chg=%b required 1", sel_chg); end
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (sel !== 2'd0) begin errors++; $display("FAIL async_sel: sel=%0d required 0", sel); end
      if (auto_mode !== 1'b0) begin errors++; $display("FAIL async_auto: auto_mode=%b required 0", auto_mode); end
      if (sel_chg !== 1'b0) begin errors++; $display("FAIL async_chg: sel_chg=%b required 0", sel_chg); end
      model_sel = 2'd0;
      sb_q.delete();
   endtask

   task automatic test_held_reset;
      int n;
      key_next_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n = cyc;
      model_sel = 2'd1;
      push_exp(n + LAT, model_sel);
      wait_cyc(n + LAT - 1);
      checks++;
      if (sel !== 2'd0) begin errors++; $display("FAIL held_early: sel=%0d required 0", sel); end
      wait_cyc(n + LAT);
      checks++;
      if (sel !== 2'd1) begin errors++; $display("FAIL held_sel: sel=%0d required 1", sel); end
      wait_cyc(n + 25);
      key_next_n = 1'b1;
      wait_cyc(n + 50);
      checks += 2;
      if (sel !== 2'd1) begin errors++; $display("FAIL held_once: sel=%0d required 1", sel); end
      if (sb_q.size() !== 0) begin errors++; $display("FAIL held_pending: %0d pending updates required 0", sb_q.size()); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_auto();
      test_priority_auto();
      test_priority_manual();
      test_reset_mid();
      test_held_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

endmodule

// File: doc/key_sel_ctrl.md
# key_sel_ctrl

Generates the 2-bit select that drives the mux41 data-path (two mux21 levels: sel[0] feeds the first-level `s`, sel[1] the second-level `s`) from the board push-buttons. It synchronises and debounces two active-low keys, then advances the select manually on each key press or automatically on a fixed period. It sits directly upstream of the mux tree and replaces hard-wired DIP-switch selects in the lab top level.

## Interface
- DEBOUNCE_CYCLES, 240000: number of consecutive stable cycles before a key level is accepted (20 ms at 12 MHz); legal range ≥2.
- AUTO_PERIOD, 12000000: cycles between automatic select advances (1 s at 12 MHz); legal range ≥2.
- clk  input  1  system clock, 12 MHz board oscillator.
- rst_n  input  1  asynchronous active-low reset.
- key_next_n  input  1  raw "next" button, low = pressed, asynchronous to clk.
- key_mode_n  input  1  raw "mode" button, low = pressed, asynchronous to clk.
- sel  output  2  registered select to the mux tree; sel[0] goes to the first-level mux21 `s`, sel[1] to the second-level mux21 `s`.
- auto_mode  output  1  registered; 1 = automatic scan, 0 = manual.
- sel_chg  output  1  registered one-cycle pulse, high in the first cycle in which sel shows a new value.

## Operation
- Per key: 2-flop synchroniser, then debounce. The debounced level `deb` resets to 1 (released). Counter `cnt` holds 0 while sync == deb. Otherwise it increments each cycle. When cnt == DEBOUNCE_CYCLES-1 and sync != deb, then deb <= sync and cnt <= 0. Any glitch shorter than DEBOUNCE_CYCLES returns cnt to 0 and produces no event.
- Press event: registered 1→0 transition of deb, one-cycle pulse. Releases produce no event.
- Mode FSM, two states:
  - MANUAL: next press → sel <= sel+1.
  - AUTO: next press ignored. Tick counter counts 0..AUTO_PERIOD-1; at AUTO_PERIOD-1 it returns to 0 and sel <= sel+1.
  - Mode press toggles the state. Entering AUTO clears the tick counter. sel is held across the toggle.
- Arithmetic: sel is a 2-bit modulo counter; 3 → 0 wrap, no saturation. Counter widths are $clog2(param) bits.
- Simultaneous events:
  - Mode press and next press in the same cycle: mode wins, next is discarded.
  - Mode press and auto tick in the same cycle: mode wins, no advance.
- sel_chg = 1 exactly in the cycle after any sel update; never asserted without a sel change.
- A key held low through reset release is debounced normally and counts as one press.

## Timing
- Reset values, asserted asynchronously: sel = 0, auto_mode = 0, sel_chg = 0, deb = 1, all counters = 0, synchronisers = 1.
- Pin-to-output latency, measured from the first clk edge sampling the new pin level:
  - Synchroniser output: 2 edges.
  - deb flips: DEBOUNCE_CYCLES edges later.
  - Press pulse: 1 edge later.
  - sel/auto_mode update: 1 edge later.
  - Total: DEBOUNCE_CYCLES + 4 edges.
- Auto advances occur every AUTO_PERIOD cycles exactly; the first one comes AUTO_PERIOD cycles after the auto_mode rising edge.
- All outputs change only on clk rising edge, except under asynchronous reset.

## Structure
- Shared package constants: SEL_W = 2, NUM_MUX_IN = 4, and the state enum {MANUAL, AUTO}.
- One sub-module, key_debounce (synchroniser + debounce + falling-edge pulse; parameter DEBOUNCE_CYCLES). It is instantiated twice.
- Top level holds the mode FSM, tick counter, sel register and sel_chg.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 8, AUTO_PERIOD = 16.
- Reset: assert rst_n = 0 mid-operation with sel = 2 and auto_mode = 1 → sel = 0, auto_mode = 0, sel_chg = 0 immediately, with no clock required.
- Clean press: key_next_n held low for 20 cycles → sel 0→1 exactly 12 edges after the first sampled low; one sel_chg pulse; release causes no change. Four presses give sel sequence 1, 2, 3, 0.
- Bounce: key_next_n low 5 cycles, high 2, low 5, high → sel unchanged, sel_chg never asserted.
- Auto mode: one mode press → auto_mode = 1; sel advances every 16 cycles (first at +16), giving 0, 1, 2, 3, 0; next presses in auto leave sel unchanged.
- Priority: debounced mode and next events aligned to the same cycle in MANUAL → auto_mode toggles, sel unchanged. A mode press aligned with a tick in AUTO → auto_mode = 0, sel unchanged.
- Held through reset: key_next_n low while rst_n releases → exactly one sel increment, 12 edges after release.
